// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: buffers keypad digits as a right-justified string and
// time-multiplexes them onto a shared common-anode 7-segment bus, with a
// blanking gap at the start of every digit slot to suppress ghosting.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic              key_ready,
  input  logic              clear,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_sel,
  output logic              buf_full,
  output logic [3:0]        count
);

  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);
  localparam logic [3:0]        CNT_FULL  = 4'(DIGITS);
  localparam logic [DIGITS-1:0] DIG_ONE   = DIGITS'(1);
  localparam logic [6:0]        SEG_OFF   = 7'h7F;

  // Hex digit to active-low segments, a on bit 6 down to g on bit 0.
  function automatic logic [6:0] enc(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Digit buffer: digit_q[0] is the rightmost (most recently entered) digit.
  logic [3:0]        digit_q [DIGITS];
  logic [3:0]        digit_d [DIGITS];
  logic [3:0]        count_q, count_d;
  logic              full_q, full_d;

  // Scan position.
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  // Registered display outputs.
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;

  logic              accept;
  logic [3:0]        slot_ext;

  // clear blocks acceptance so a simultaneous key is dropped.
  assign key_ready = (count_q < CNT_FULL) && !clear;
  assign accept    = key_valid && key_ready;
  assign slot_ext  = 4'(slot_q);

  assign seg      = seg_q;
  assign dig_sel  = sel_q;
  assign buf_full = full_q;
  assign count    = count_q;

  // Next buffer state: clear has priority, otherwise shift in an accepted key.
  always_comb begin
    digit_d = digit_q;
    count_d = count_q;
    full_d  = full_q;
    if (clear) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_d[i] = 4'h0;
      end
      count_d = 4'h0;
      full_d  = 1'b0;
    end else if (accept) begin
      digit_d[0] = key_code;
      for (int i = 1; i < DIGITS; i++) begin
        digit_d[i] = digit_q[i-1];
      end
      count_d = count_q + 4'd1;
      full_d  = (count_q == (CNT_FULL - 4'd1));
    end
  end

  // Next scan position: slot advances on the same edge the prescaler wraps.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    slot_d = slot_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
    end
  end

  // Display decode from the current state; a leading empty position keeps its
  // digit enable but shows nothing, except slot 0 which shows "0" when empty.
  always_comb begin
    seg_d = SEG_OFF;
    sel_d = '1;
    if (cnt_q >= CNT_BLANK) begin
      sel_d = ~(DIG_ONE << slot_q);
      if ((slot_ext < count_q) || ((slot_q == '0) && (count_q == 4'h0))) begin
        seg_d = enc(digit_q[slot_q]);
      end
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '{default: 4'h0};
      count_q <= 4'h0;
      full_q  <= 1'b0;
    end else begin
      digit_q <= digit_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Scan prescaler and slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  // Output registers; reset forces the bus dark immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_OFF;
      sel_q <= '1;
    end else begin
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller for the multi-digit common-anode 7-segment display, fed by the 4x4 keypad scanner. It buffers entered key codes as a right-justified digit string. It time-multiplexes the shared segment bus across DIGITS positions, with a blanking gap at each slot start to prevent ghosting. It sits between the keypad decode path and the board display pins and is the only block that drives the segment bus.

## Interface
- DIGITS, 4, number of display positions, legal 2..8
- SCAN_DIV, 50000, clk cycles per digit slot, must be > BLANK_CYC
- BLANK_CYC, 1000, cycles at the start of each slot with display blanked, must be >= 1
- clk  in  1  system clock; one clock domain, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  key code present this cycle
- key_code  in  4  hex value 0x0..0xF of the pressed key
- key_ready  out  1  buffer can accept a key
- clear  in  1  synchronous clear of the digit buffer
- seg  out  7  segments a..g on bits 6..0, active-low (0 = lit)
- dig_sel  out  DIGITS  digit enables, active-low one-hot, bit 0 = rightmost
- buf_full  out  1  count == DIGITS
- count  out  4  number of digits entered, 0..DIGITS

## Operation
- Buffer: DIGITS 4-bit registers d[0..DIGITS-1] plus count.
- Accept: key_valid && key_ready && !clear at a rising edge.
  - On accept, d[i] <= d[i-1] for i>0 and d[0] <= key_code.
  - count <= count+1.
- key_ready = (count < DIGITS) && !clear, combinational.
- key_valid while key_ready=0 is dropped; buffer and count are unchanged; no queuing.
- clear: d[*] <= 0 and count <= 0 at the next edge. When clear and key_valid are asserted together, clear wins and the key is dropped.
- Prescaler: cnt counts 0..SCAN_DIV-1 and wraps. On wrap, slot <= (slot == DIGITS-1) ? 0 : slot+1.
- Display function, registered into seg/dig_sel:
  - If cnt < BLANK_CYC: seg = 7'h7F and dig_sel = all ones.
  - Else if slot < count, or slot == 0 with count == 0: dig_sel bit slot = 0, others = 1; seg = enc(d[slot]). With count == 0, d[0] is 0, so digit 0 shows "0".
  - Else: dig_sel asserts the slot, and seg = 7'h7F (leading-position blank).
- Encoding enc, 0..F:
  - 0000001, 1001111, 0010010, 0000110
  - 1001100, 0100100, 0100000, 0001111
  - 0000000, 0000100, 0001000, 1100000
  - 0110001, 1000010, 0110000, 0111000
- buf_full and count are registered state, not decoded from a sliding count.

## Timing
- Reset values: cnt=0, slot=0, d[*]=0, count=0, seg=7'h7F, dig_sel=all ones, buf_full=0, key_ready=1 (given clear=0).
- Reset asserted mid-scan or mid-entry takes effect immediately and asynchronously. The first post-reset slot is slot 0 with a full blank period.
- Accept latency: count, buf_full and d update at the accepting edge. key_ready falls the same cycle the buffer becomes full.
- seg/dig_sel lag the (slot, cnt, d, count) state by exactly one clk.
  - A buffer change is visible the cycle after it happens if its slot is currently unblanked, otherwise at that slot's next unblanked period.
- Slot period is SCAN_DIV cycles: BLANK_CYC blank, then SCAN_DIV-BLANK_CYC lit. Full refresh takes DIGITS*SCAN_DIV cycles.
- Wrap: the slot DIGITS-1 to 0 transition occurs at the same edge as cnt SCAN_DIV-1 to 0. No extra idle cycle.
- dig_sel is never non-one-hot. Exactly zero or one bit is low in every cycle.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
- Reset then idle 32 cycles -> seg=7'h7F/dig_sel=4'hF for 2 cycles per slot. Slot 0 shows seg=0000001 with dig_sel=1110. Slots 1-3 stay blank with their dig_sel bit low; count=0.
- Keys 0x1, 0xA, 0x3 on consecutive cycles -> count=3, key_ready=1. Lit slots show slot 2 = 1001111, slot 1 = 0001000, slot 0 = 0000110, slot 3 blank.
- Keys 1,2,3,4, then 5 -> count=4, buf_full=1, key_ready=0 after the 4th; the 5th is ignored and d = 1,2,3,4 unchanged.
- clear and key_valid (0x7) in the same cycle with count=2 -> count=0 next cycle, 0x7 is not stored, and the display shows only "0" on slot 0.
- Assert rst during a lit cycle of slot 2 with count=3 -> seg=7'h7F, dig_sel=4'hF and count=0 immediately. After release, scanning restarts at slot 0 with cnt=0.
- Across 3 full refreshes (96 cycles) -> at most one dig_sel bit low per cycle; every slot transition is preceded by exactly 2 blank cycles.
